// File: rtl/dma_line_engine.sv
// rtl/dma_line_engine.sv - cache-line DMA engine between host line FIFOs and a word-wide memory port
// Optional macro DMA_TIMEOUT_EN adds a read-response timeout that aborts with err.
module dma_line_engine #(
  parameter int CL_SIZE_WIDTH  = 512,
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ADDR_STRIDE    = 4,
  parameter int LINE_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_dir,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LINE_CNT_WIDTH-1:0] cmd_lines,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      host_empty,
  input  logic [CL_SIZE_WIDTH-1:0]  host_rd_data,
  output logic                      host_rd_en,
  input  logic                      host_full,
  output logic [CL_SIZE_WIDTH-1:0]  host_wr_data,
  output logic                      host_wr_en,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WORD_SIZE-1:0]      mem_wdata,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [WORD_SIZE-1:0]      mem_rdata
);

  localparam int WORDS = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    IDLE, H2M_POP, H2M_WR, M2H_RD, M2H_WAIT, M2H_PUSH, FINISH
  } state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [LINE_CNT_WIDTH-1:0] lines_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CL_SIZE_WIDTH-1:0]  line_q;
  logic                      accept, last_word, last_line, tmo_hit;

  assign accept    = cmd_valid && (state == IDLE);
  assign last_word = (idx_q == LAST_IDX);
  assign last_line = (lines_q <= LINE_CNT_WIDTH'(1));

`ifdef DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign tmo_hit = (state == M2H_WAIT) && !mem_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = (state == FINISH) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == M2H_WAIT && !mem_valid) tmo_q <= tmo_q + 1'b1;
      else                                 tmo_q <= '0;
      if (accept)       err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (cmd_lines == '0) ? FINISH : (cmd_dir ? M2H_RD : H2M_POP);
      H2M_POP:  if (!host_empty) state_nxt = H2M_WR;
      H2M_WR:   if (mem_ready && last_word) state_nxt = last_line ? FINISH : H2M_POP;
      M2H_RD:   if (mem_ready) state_nxt = M2H_WAIT;
      M2H_WAIT: begin
        if (mem_valid)    state_nxt = last_word ? M2H_PUSH : M2H_RD;
        else if (tmo_hit) state_nxt = FINISH;
      end
      M2H_PUSH: if (!host_full) state_nxt = last_line ? FINISH : M2H_RD;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    host_rd_en = 1'b0;
    host_wr_en = 1'b0;
    mem_en     = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      IDLE:     cmd_ready = 1'b1;
      H2M_POP:  begin busy = 1'b1; host_rd_en = !host_empty; end
      H2M_WR:   begin busy = 1'b1; mem_en = 1'b1; mem_wr_en = 1'b1; end
      M2H_RD:   begin busy = 1'b1; mem_en = 1'b1; end
      M2H_WAIT: busy = 1'b1;
      M2H_PUSH: begin busy = 1'b1; host_wr_en = !host_full; end
      FINISH:   begin busy = 1'b1; done = 1'b1; end
      default:  ;
    endcase
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = line_q[idx_q*WORD_SIZE +: WORD_SIZE];
  assign host_wr_data = line_q;

  // One shared line buffer: unpack source for H2M, gather target for M2H.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      lines_q <= '0;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= cmd_addr;
          lines_q <= cmd_lines;
          idx_q   <= '0;
        end
        H2M_POP: if (!host_empty) begin
          line_q <= host_rd_data;
          idx_q  <= '0;
        end
        H2M_WR: if (mem_ready) begin
          addr_q <= addr_q + STRIDE;
          idx_q  <= idx_q + 1'b1;
          if (last_word && lines_q != '0) lines_q <= lines_q - 1'b1;
        end
        M2H_RD: if (mem_ready) addr_q <= addr_q + STRIDE;
        M2H_WAIT: if (mem_valid) begin
          line_q[idx_q*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
          if (!last_word) idx_q <= idx_q + 1'b1;
        end
        M2H_PUSH: if (!host_full) begin
          idx_q <= '0;
          if (lines_q != '0) lines_q <= lines_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_line_engine.sv
// tb/tb_dma_line_engine.sv - table-driven bench for dma_line_engine with FIFO and memory models
module tb_dma_line_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready, cmd_dir;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_lines;
  logic         busy, done, err;
  logic         host_empty, host_rd_en, host_full, host_wr_en;
  logic [511:0] host_rd_data, host_wr_data;
  logic         mem_en, mem_wr_en, mem_ready, mem_valid;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_line_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_lines(cmd_lines),
    .busy(busy), .done(done), .err(err),
    .host_empty(host_empty), .host_rd_data(host_rd_data), .host_rd_en(host_rd_en),
    .host_full(host_full), .host_wr_data(host_wr_data), .host_wr_en(host_wr_en),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        dir;
    logic [31:0] addr;
    logic [15:0] lines;
    int          empty_until;
    int          full_until;
    logic        toggle;
    logic        no_valid;
    int          rst_at;
    int          exp_writes;
    int          exp_pops;
    int          exp_reads;
    int          exp_pushes;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic dir, logic [31:0] addr, logic [15:0] lines,
                              int empty_until, int full_until, logic toggle, logic no_valid,
                              int rst_at, int ew, int ep, int er, int epu, int ed, logic eerr);
    vec_t v;
    v.dir = dir; v.addr = addr; v.lines = lines;
    v.empty_until = empty_until; v.full_until = full_until;
    v.toggle = toggle; v.no_valid = no_valid; v.rst_at = rst_at;
    v.exp_writes = ew; v.exp_pops = ep; v.exp_reads = er; v.exp_pushes = epu;
    v.exp_done = ed; v.exp_err = eerr;
    return v;
  endfunction

  function automatic logic [511:0] host_line(int k);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'(k*16 + i + 1);
    return l;
  endfunction

  function automatic logic [511:0] exp_line(logic [31:0] base, int k);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(64*k + 4*i);
    return l;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 512'({mem_en, mem_wr_en, host_rd_en, host_wr_en, busy, done, err}), 512'(0));
    check({name, "_addr"}, 512'(mem_addr), 512'(0));
    check({name, "_wdata"}, 512'(mem_wdata), 512'(0));
    check({name, "_line"}, host_wr_data, 512'(0));
    check({name, "_cmd_ready"}, 512'(cmd_ready), 512'(1));
  endtask

  task automatic run_case(input vec_t v);
    int          cyc = 0, writes = 0, pops = 0, reads = 0, pushes = 0, dones = 0, done_cyc = -1;
    logic        pend = 1'b0, stall = 1'b0, st_wr = 1'b0;
    logic [31:0] pend_addr = '0, st_addr = '0, st_wdata = '0, exp_a;
    while (cyc < 400 && (dones == 0 || cyc <= done_cyc + 1)) begin
      @(negedge clk);
      cmd_valid    = (cyc == 0);
      cmd_dir      = v.dir;
      cmd_addr     = v.addr;
      cmd_lines    = v.lines;
      host_empty   = (cyc < v.empty_until);
      host_full    = (cyc <= v.full_until);
      host_rd_data = host_line(pops);
      mem_ready    = v.toggle ? cyc[0] : 1'b1;
      mem_valid    = pend && !v.no_valid;
      mem_rdata    = pend_addr;
      pend         = 1'b0;
      #1;
      if (cyc == 0) check("cmd_ready_idle", 512'(cmd_ready), 512'(1));
      if (cyc == 1) check("busy_after_accept", 512'(busy), 512'(1));
      check("rd_wr_exclusive", 512'(host_rd_en & host_wr_en), 512'(0));
      if (stall) begin
        check("hold_mem_en", 512'(mem_en), 512'(1));
        check("hold_addr", 512'(mem_addr), 512'(st_addr));
        check("hold_wr_en", 512'(mem_wr_en), 512'(st_wr));
        if (st_wr) check("hold_wdata", 512'(mem_wdata), 512'(st_wdata));
      end
      if (mem_en && mem_ready) begin
        exp_a = v.addr + 32'(4 * (mem_wr_en ? writes : reads));
        check("mem_addr", 512'(mem_addr), 512'(exp_a));
        if (mem_wr_en) begin
          check("mem_wdata", 512'(mem_wdata), 512'(writes + 1));
          writes++;
        end else begin
          pend = 1'b1;
          pend_addr = mem_addr;
          reads++;
        end
      end
      stall    = mem_en && !mem_ready;
      st_wr    = mem_wr_en;
      st_addr  = mem_addr;
      st_wdata = mem_wdata;
      if (host_rd_en) begin
        check("pop_not_empty", 512'(host_empty), 512'(0));
        pops++;
      end
      if (host_wr_en) begin
        check("push_not_full", 512'(host_full), 512'(0));
        check("push_line", host_wr_data, exp_line(v.addr, pushes));
        pushes++;
      end
      if (done) begin
        check("err", 512'(err), 512'(v.exp_err));
        check("cmd_ready_finish", 512'(cmd_ready), 512'(0));
        dones++;
        done_cyc = cyc;
      end
      if (cyc == v.rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        check("no_done_before_reset", 512'(dones), 512'(0));
        @(negedge clk);
        check("no_done_in_reset", 512'(done), 512'(0));
        mem_valid = 1'b0;
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      cyc++;
    end
    check("writes", 512'(writes), 512'(v.exp_writes));
    check("pops", 512'(pops), 512'(v.exp_pops));
    check("reads", 512'(reads), 512'(v.exp_reads));
    check("pushes", 512'(pushes), 512'(v.exp_pushes));
    check("done_count", 512'(dones), 512'(1));
    check("done_cycle", 512'(done_cyc), 512'(v.exp_done));
  endtask

  initial begin
    //             dir addr          lines empty full tog noval rst  wr pop rd push done err
    vecs.push_back(mk(0, 32'h0000_5000, 1,  0, -1, 0, 0, -1, 16, 1,  0, 0, 18, 0));
    vecs.push_back(mk(1, 32'h0000_6000, 2,  0, -1, 0, 0, -1,  0, 0, 32, 2, 67, 0));
    vecs.push_back(mk(0, 32'h0000_7000, 2, 10, -1, 1, 0, -1, 32, 2,  0, 0, 74, 0));
    vecs.push_back(mk(1, 32'h0000_8000, 1,  0, 37, 0, 0, -1,  0, 0, 16, 1, 39, 0));
    vecs.push_back(mk(0, 32'h0000_0100, 0,  0, -1, 0, 0, -1,  0, 0,  0, 0,  1, 0));
    vecs.push_back(mk(0, 32'hFFFF_FFF8, 1,  0, -1, 0, 0, -1, 16, 1,  0, 0, 18, 0));
    vecs.push_back(mk(1, 32'h0000_9000, 1,  0, -1, 0, 0, 15,  0, 0,  0, 0,  0, 0));
    vecs.push_back(mk(0, 32'h0000_5000, 1,  0, -1, 0, 0, -1, 16, 1,  0, 0, 18, 0));
`ifdef DMA_TIMEOUT_EN
    vecs.push_back(mk(1, 32'h0000_A000, 1,  0, -1, 0, 1, -1,  0, 0,  1, 0, 258, 1));
`endif

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_dir      = 1'b0;
    cmd_addr     = '0;
    cmd_lines    = '0;
    host_empty   = 1'b1;
    host_full    = 1'b0;
    host_rd_data = '0;
    mem_ready    = 1'b0;
    mem_valid    = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_case(vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_line_engine.md
Name: dma_line_engine

Overview:
Parametrised cache-line DMA engine bridging host-side line FIFOs (CL_SIZE_WIDTH bits) and a word-wide local memory port (WORD_SIZE bits). A descriptor gives direction, base address and line count. Host-to-memory (H2M) unpacks each line into words written at ascending addresses; memory-to-host (M2H) gathers words into lines and pushes them to the host. It replaces the fixed single-line, fixed-address FSM with multi-line bursts, programmable base/stride, full memory handshakes and completion/error reporting.

Parameters:
CL_SIZE_WIDTH, 512, host line width in bits; integer multiple of WORD_SIZE
WORD_SIZE, 32, memory word width in bits
ADDR_WIDTH, 32, memory address width
ADDR_STRIDE, 4, address increment per word
LINE_CNT_WIDTH, 16, width of the line-count field
TIMEOUT_CYCLES, 256, read-response timeout; used only with DMA_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  high in IDLE; descriptor accepted when cmd_valid & cmd_ready
cmd_dir  in  1  0 = H2M, 1 = M2H
cmd_addr  in  ADDR_WIDTH  base memory address
cmd_lines  in  LINE_CNT_WIDTH  number of lines
busy  out  1  descriptor in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done
host_empty  in  1  host read FIFO empty
host_rd_data  in  CL_SIZE_WIDTH  show-ahead head of host read FIFO
host_rd_en  out  1  pop host read FIFO
host_full  in  1  host write FIFO full
host_wr_data  out  CL_SIZE_WIDTH  line to host
host_wr_en  out  1  push host write FIFO
mem_en  out  1  memory request valid
mem_wr_en  out  1  1 = write, 0 = read (meaningful only with mem_en)
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  WORD_SIZE  write data
mem_ready  in  1  request accepted this cycle
mem_valid  in  1  read data valid
mem_rdata  in  WORD_SIZE  read data

Behaviour:
- Reset: state IDLE; cmd_ready=1; all other outputs, address register, counters and line buffer 0.
- WORDS = CL_SIZE_WIDTH/WORD_SIZE. Word i occupies line bits [i*WORD_SIZE +: WORD_SIZE]; i=0 goes to the lowest address.
- States: IDLE, H2M_POP, H2M_WR, M2H_RD, M2H_WAIT, M2H_PUSH, FINISH.
- IDLE: on accept, latch addr/lines/dir. cmd_lines=0 -> FINISH (no traffic). Otherwise -> H2M_POP or M2H_RD. busy=1 from the cycle after accept through FINISH.
- H2M_POP: while host_empty, wait. Otherwise host_rd_en=1 for exactly one cycle, capture host_rd_data into the line buffer, word index=0, -> H2M_WR.
- H2M_WR: mem_en=1, mem_wr_en=1, mem_addr=addr, mem_wdata=word[index]. Hold all request signals stable until mem_ready. On mem_ready: addr+=ADDR_STRIDE and index++. At the last word, decrement the line count -> H2M_POP, or FINISH if the count reaches 0.
- M2H_RD: mem_en=1, mem_wr_en=0, mem_addr=addr, held until mem_ready, then addr+=ADDR_STRIDE -> M2H_WAIT. One outstanding read only. mem_valid is never asserted in the acceptance cycle.
- M2H_WAIT: on mem_valid, store mem_rdata in slot[index]. If not the last word, index++ -> M2H_RD; otherwise -> M2H_PUSH.
- M2H_PUSH: while host_full, wait with host_wr_en=0. Otherwise host_wr_en=1 for one cycle with the line on host_wr_data. Decrement the line count -> M2H_RD (index=0), or FINISH when it reaches 0.
- FINISH: done=1 for one cycle -> IDLE. cmd_ready=0 in FINISH; cmd_valid there is not accepted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The line counter never underflows.
- host_rd_en and host_wr_en never assert in the same cycle; each asserts at most once per line.
- Reset mid-operation: the partial line is discarded and no done is emitted.

Optional Feature:
DMA_TIMEOUT_EN
- Defined: a counter runs in M2H_WAIT. If mem_valid is absent for TIMEOUT_CYCLES consecutive cycles, abort to FINISH with done=1 and err=1; the partial line is not pushed.
- Undefined: M2H_WAIT waits indefinitely; err is tied 0.

Test Plan:
1. H2M, cmd_addr=0x5000, cmd_lines=1, line=word i = i+1, mem_ready=1 always -> 16 writes at 0x5000..0x503C with data 1..16; one host_rd_en; done pulses the cycle after the last write.
2. M2H, cmd_addr=0x6000, cmd_lines=2, memory returns rdata=addr one cycle after accept -> two host_wr_en; line0 word i = 0x6000+4i, line1 starts at 0x6040.
3. H2M with host_empty=1 for 10 cycles and mem_ready toggling 1/0 -> no pop while empty; requests held stable while mem_ready=0; addresses have no gaps or repeats.
4. M2H with host_full=1 for 5 cycles after the line completes -> host_wr_en stays 0 until full drops, then exactly one push.
5. cmd_lines=0, then cmd_addr=0xFFFFFFF8 with 1 line -> done with no traffic; second command's addresses wrap to 0x00000000..0x00000034.
6. Reset asserted mid-M2H at word 7 -> all outputs 0 at once; no done; a new command completes normally. With DMA_TIMEOUT_EN, withheld mem_valid for 256 cycles -> done=1 and err=1, no push.
